// File: rtl/la_capture.sv
// Logic-analyzer capture engine: circular sample buffer with mask/value trigger,
// programmable pre-trigger depth, and trigger-relative readout.
module la_capture #(
  parameter int DATA_W = 47,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sample_en,
  input  logic              arm,
  input  logic [AW-1:0]     pretrig,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic              trig_edge,
  output logic [2:0]        state,
  output logic              triggered,
  output logic              done,
  output logic [AW-1:0]     trig_addr,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] ZERO_AW = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_AW  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONES_AW = {AW{1'b1}};

  state_t            state_r;
  state_t            next_state_s;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     cnt_r;
  logic [AW-1:0]     pretrig_r;
  logic              edge_r;
  logic              prev_match_r;
  logic [AW-1:0]     trig_addr_r;
  logic              triggered_r;
  logic              done_r;
  logic [DATA_W-1:0] rd_data_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              match_s;
  logic              capturing_s;
  logic              qual_s;
  logic              trig_hit_s;
  logic              we_s;
  logic [AW-1:0]     wr_addr_s;
  logic [AW-1:0]     post_cnt_s;
  logic [AW-1:0]     rd_phys_s;

  assign match_s = (((data_i ^ trig_value) & trig_mask) == {DATA_W{1'b0}});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; arm overrides whatever the current state would do
  always_comb begin
    next_state_s = state_r;
    if (arm) begin
      if ((pretrig == ZERO_AW) || (sample_en && (pretrig == ONE_AW))) begin
        next_state_s = S_ARMED;
      end else begin
        next_state_s = S_PRE;
      end
    end else begin
      case (state_r)
        S_IDLE:  next_state_s = S_IDLE;
        S_PRE: begin
          if (sample_en && ((cnt_r + ONE_AW) == pretrig_r)) begin
            next_state_s = S_ARMED;
          end else begin
            next_state_s = S_PRE;
          end
        end
        S_ARMED: begin
          if (trig_hit_s) begin
            next_state_s = (post_cnt_s == ZERO_AW) ? S_DONE : S_POST;
          end else begin
            next_state_s = S_ARMED;
          end
        end
        S_POST: begin
          if (sample_en && (cnt_r == ONE_AW)) begin
            next_state_s = S_DONE;
          end else begin
            next_state_s = S_POST;
          end
        end
        S_DONE:  next_state_s = S_DONE;
        default: next_state_s = S_IDLE;
      endcase
    end
  end

  // Write/trigger controls; the arm-cycle sample becomes address 0 of the new capture
  always_comb begin
    capturing_s = (state_r == S_PRE) || (state_r == S_ARMED) || (state_r == S_POST);
    qual_s      = sample_en && capturing_s && !arm;
    trig_hit_s  = qual_s && (state_r == S_ARMED) && match_s && (!edge_r || !prev_match_r);
    post_cnt_s  = ONES_AW - pretrig_r;
    if (arm) begin
      we_s      = sample_en;
      wr_addr_s = ZERO_AW;
    end else begin
      we_s      = qual_s;
      wr_addr_s = wr_ptr_r;
    end
    rd_phys_s = trig_addr_r - pretrig_r + rd_addr;
  end

  // Capture datapath: pointers, counters, trigger bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= ZERO_AW;
      cnt_r        <= ZERO_AW;
      pretrig_r    <= ZERO_AW;
      edge_r       <= 1'b0;
      prev_match_r <= 1'b0;
      trig_addr_r  <= ZERO_AW;
      triggered_r  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= (next_state_s == S_DONE);
      if (arm) begin
        pretrig_r    <= pretrig;
        edge_r       <= trig_edge;
        wr_ptr_r     <= sample_en ? ONE_AW : ZERO_AW;
        cnt_r        <= sample_en ? ONE_AW : ZERO_AW;
        prev_match_r <= sample_en & match_s;
        triggered_r  <= 1'b0;
      end else if (qual_s) begin
        wr_ptr_r     <= wr_ptr_r + ONE_AW;
        prev_match_r <= match_s;
        case (state_r)
          S_PRE:   cnt_r <= cnt_r + ONE_AW;
          S_ARMED: begin
            if (trig_hit_s) begin
              trig_addr_r <= wr_ptr_r;
              triggered_r <= 1'b1;
              cnt_r       <= post_cnt_s;
            end else begin
              cnt_r <= cnt_r;
            end
          end
          S_POST:  cnt_r <= cnt_r - ONE_AW;
          default: cnt_r <= cnt_r;
        endcase
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Sample buffer write port
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wr_addr_s] <= data_i;
    end
  end

  // Registered readout, trigger-relative addressing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_data_r <= mem_r[rd_phys_s];
    end
  end

  assign state     = state_r;
  assign triggered = triggered_r;
  assign done      = done_r;
  assign trig_addr = trig_addr_r;
  assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_la_capture.sv
// Directed bench for la_capture (DATA_W=8, DEPTH=16); expectations queued by
// stimulus and checked by a negedge monitor.
module tb_la_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       sample_en = 1'b0;
  logic       arm = 1'b0;
  logic [3:0] pretrig = 4'd0;
  logic [7:0] trig_mask = 8'h00;
  logic [7:0] trig_value = 8'h00;
  logic       trig_edge = 1'b0;
  logic [2:0] state;
  logic       triggered;
  logic       done;
  logic [3:0] trig_addr;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;

  la_capture #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .sample_en(sample_en), .arm(arm),
    .pretrig(pretrig), .trig_mask(trig_mask), .trig_value(trig_value),
    .trig_edge(trig_edge), .state(state), .triggered(triggered), .done(done),
    .trig_addr(trig_addr), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_rd;
    logic [2:0] st;
    logic       trg;
    logic       dn;
    logic [3:0] ta;
    bit         cta;
    logic [7:0] d;
    bit         cd;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic rd_pend = 1'b0;
  logic rd_vld = 1'b0;
  logic st_vld = 1'b0;

  always @(posedge clk) rd_vld <= rd_pend;

  task automatic pop_cmp(input bit want_rd);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL queue_empty: output presented with no expectation");
      return;
    end
    e = exp_q.pop_front();
    if (e.is_rd != want_rd) begin
      n_bad++;
      $display("FAIL %s: expectation kind out of order", e.tag);
    end else if (want_rd) begin
      if (rd_data !== e.d) begin
        n_bad++;
        $display("FAIL %s: rd_data got %h want %h", e.tag, rd_data, e.d);
      end
    end else if (state !== e.st || triggered !== e.trg || done !== e.dn ||
                 (e.cta && trig_addr !== e.ta) || (e.cd && rd_data !== e.d)) begin
      n_bad++;
      $display("FAIL %s: state/trig/done/taddr/rd got %0d/%b/%b/%0d/%h want %0d/%b/%b/%0d/%h",
               e.tag, state, triggered, done, trig_addr, rd_data, e.st, e.trg, e.dn, e.ta, e.d);
    end
  endtask

  always @(negedge clk) begin
    if (rd_vld) pop_cmp(1'b1);
    if (st_vld) pop_cmp(1'b0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_st(input string tag, input logic [2:0] st, input logic trg,
                          input logic dn, input bit cta, input logic [3:0] ta,
                          input bit cd, input logic [7:0] d);
    exp_t e;
    e.is_rd = 1'b0; e.st = st; e.trg = trg; e.dn = dn; e.ta = ta; e.cta = cta;
    e.d = d; e.cd = cd; e.tag = tag;
    exp_q.push_back(e);
    st_vld = 1'b1;
    @(negedge clk);
    #1;
    st_vld = 1'b0;
  endtask

  task automatic st_chk(input string tag, input logic [2:0] st, input logic trg, input logic dn);
    check_st(tag, st, trg, dn, 1'b0, 4'd0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] d);
    data_i = d;
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
  endtask

  task automatic arm_cap(input logic [3:0] pt, input logic edg, input logic [7:0] mask,
                         input logic [7:0] val, input logic en, input logic [7:0] d);
    pretrig = pt; trig_edge = edg; trig_mask = mask; trig_value = val;
    data_i = d; sample_en = en; arm = 1'b1;
    step();
    arm = 1'b0; sample_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] idx, input logic [7:0] d);
    exp_t e;
    e.is_rd = 1'b1; e.st = 3'd0; e.trg = 1'b0; e.dn = 1'b0; e.ta = 4'd0; e.cta = 1'b0;
    e.d = d; e.cd = 1'b1; e.tag = tag;
    exp_q.push_back(e);
    rd_addr = idx;
    rd_pend = 1'b1;
    step();
  endtask

  task automatic rd_end();
    rd_pend = 1'b0;
    step();
    step();
  endtask

  initial begin
    // Reset state
    step(); step();
    check_st("reset", 3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 8'h00);
    rst_n = 1'b1;
    step();
    st_chk("idle_after_reset", 3'd0, 1'b0, 1'b0);

    // Level trigger at 0x20, pretrig 4
    arm_cap(4'd4, 1'b0, 8'hFF, 8'h20, 1'b0, 8'h00);
    st_chk("t1_pre", 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(8'(i));
    st_chk("t1_armed", 3'd2, 1'b0, 1'b0);
    for (int i = 4; i < 32; i++) send(8'(i));
    st_chk("t1_no_early_trig", 3'd2, 1'b0, 1'b0);
    send(8'h20);
    check_st("t1_trig", 3'd3, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'h00);
    for (int i = 8'h21; i <= 8'h2A; i++) send(8'(i));
    st_chk("t1_post_last", 3'd3, 1'b1, 1'b0);
    send(8'h2B);
    st_chk("t1_done", 3'd4, 1'b1, 1'b1);
    send(8'hFF);
    st_chk("t1_done_hold", 3'd4, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) rd_chk("t1_rd", 4'(i), 8'(8'h1C + i));
    rd_end();

    // Mask 0, pretrig 0: first sample triggers
    arm_cap(4'd0, 1'b0, 8'h00, 8'h55, 1'b0, 8'h00);
    st_chk("t2_armed", 3'd2, 1'b0, 1'b0);
    send(8'h00);
    check_st("t2_trig", 3'd3, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'h00);
    for (int i = 1; i < 15; i++) send(8'(i));
    st_chk("t2_post_last", 3'd3, 1'b1, 1'b0);
    send(8'h0F);
    st_chk("t2_done", 3'd4, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) rd_chk("t2_rd", 4'(i), 8'(i));
    rd_end();

    // sample_en toggling; unqualified cycles carry the trigger value
    arm_cap(4'd4, 1'b0, 8'hFF, 8'h08, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      send(8'(i));
      data_i = 8'h08; sample_en = 1'b0;
      step();
    end
    st_chk("t3_gaps_no_trig", 3'd2, 1'b0, 1'b0);
    send(8'h08);
    check_st("t3_trig", 3'd3, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 8'h00);
    for (int i = 9; i <= 8'h13; i++) begin
      send(8'(i));
      data_i = 8'hEE; sample_en = 1'b0;
      step();
    end
    st_chk("t3_done", 3'd4, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) rd_chk("t3_rd", 4'(i), 8'(8'h04 + i));
    rd_end();

    // Match during PRE ignored; trigger value changed in ARMED
    arm_cap(4'd4, 1'b0, 8'hFF, 8'h02, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) send(8'(i));
    st_chk("t4_pre_match_ignored", 3'd2, 1'b0, 1'b0);
    trig_value = 8'h30;
    for (int i = 4; i < 8'h30; i++) send(8'(i));
    send(8'h30);
    check_st("t4_trig", 3'd3, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'h00);
    for (int i = 8'h31; i <= 8'h3B; i++) send(8'(i));
    st_chk("t4_done", 3'd4, 1'b1, 1'b1);
    rd_chk("t4_rd0", 4'd0, 8'h2C);
    rd_chk("t4_rd4", 4'd4, 8'h30);
    rd_chk("t4_rd15", 4'd15, 8'h3B);
    rd_end();

    // Edge mode, data held at 0x20 across arm (arm-cycle sample must not trigger)
    arm_cap(4'd0, 1'b1, 8'hFF, 8'h20, 1'b1, 8'h20);
    st_chk("t5_arm_wins", 3'd2, 1'b0, 1'b0);
    send(8'h20);
    st_chk("t5_held_no_trig", 3'd2, 1'b0, 1'b0);
    send(8'h21);
    send(8'h20);
    check_st("t5_edge_trig", 3'd3, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 8'h00);
    for (int i = 0; i < 14; i++) send(8'(8'h40 + i));
    st_chk("t5_post_last", 3'd3, 1'b1, 1'b0);
    send(8'h4E);
    st_chk("t5_done", 3'd4, 1'b1, 1'b1);
    rd_chk("t5_rd0", 4'd0, 8'h20);
    rd_chk("t5_rd1", 4'd1, 8'h40);
    rd_chk("t5_rd15", 4'd15, 8'h4E);
    rd_end();

    // Re-arm in ARMED restarts at wr_ptr 0; reset in POST
    arm_cap(4'd2, 1'b0, 8'hFF, 8'h05, 1'b0, 8'h00);
    send(8'h00); send(8'h01);
    st_chk("t6_armed", 3'd2, 1'b0, 1'b0);
    send(8'h02); send(8'h03); send(8'h04);
    arm_cap(4'd2, 1'b0, 8'hFF, 8'h05, 1'b0, 8'h00);
    st_chk("t6_rearm", 3'd1, 1'b0, 1'b0);
    send(8'h10); send(8'h11);
    send(8'h05);
    check_st("t6_trig_addr", 3'd3, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
    rst_n = 1'b0;
    check_st("t6_async_reset", 3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    st_chk("t6_idle_after_release", 3'd0, 1'b0, 1'b0);

    step(); step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/la_capture.md
LA_CAPTURE -- requirements
Module: la_capture

Interface
REQ-001 Parameter DATA_W, default 47, width of the probed sample bus.
REQ-002 Parameter DEPTH, default 1024, capture buffer depth in samples; power of two, at least 4.
REQ-003 Derived AW = log2(DEPTH), address width.
REQ-004 Port clk  input  1  sample and logic clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port data_i  input  DATA_W  probed sample bus.
REQ-007 Port sample_en  input  1  sample qualifier; only cycles with sample_en=1 are stored or evaluated.
REQ-008 Port arm  input  1  single-cycle pulse that starts or restarts a capture.
REQ-009 Port pretrig  input  AW  pre-trigger sample count, latched on arm; legal range 0..DEPTH-1.
REQ-010 Port trig_mask  input  DATA_W  per-bit trigger compare enable.
REQ-011 Port trig_value  input  DATA_W  trigger compare value.
REQ-012 Port trig_edge  input  1  trigger mode, latched on arm: 0 = level, 1 = edge.
REQ-013 Port state  output  3  FSM state: IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.
REQ-014 Port triggered  output  1  high from the trigger sample until the next arm.
REQ-015 Port done  output  1  high while in DONE.
REQ-016 Port trig_addr  output  AW  physical buffer address of the trigger sample.
REQ-017 Port rd_addr  input  AW  logical readout index; 0 = oldest stored sample.
REQ-018 Port rd_data  output  DATA_W  readout data, registered, 1-cycle latency.

Function
REQ-019 A sample matches when ((data_i XOR trig_value) AND trig_mask) = 0.
REQ-020 Level mode: a trigger is a qualified matching sample in ARMED; edge mode: a qualified matching sample whose previous qualified sample did not match.
REQ-021 The previous-match flag updates only on qualified samples, in every capturing state, and clears on arm.
REQ-022 arm in any state: latch pretrig and trig_edge, clear wr_ptr, sample count, triggered and done; next state PRE, or ARMED if pretrig = 0.
REQ-023 PRE: each qualified sample is written at wr_ptr and wr_ptr increments; after pretrig samples, go to ARMED; matches are ignored in PRE.
REQ-024 ARMED: qualified samples are written circularly, with wr_ptr wrapping DEPTH-1 to 0.
REQ-025 A trigger sample is written, trig_addr is set to its address, triggered is set, and the state goes to POST with post count = DEPTH-1-pretrig.
REQ-026 POST: qualified samples are written until the post count is exhausted, then DONE; if the post count is 0, go directly to DONE after the trigger sample.
REQ-027 DONE: no writes; the state holds until arm.
REQ-028 Exactly DEPTH samples are valid in DONE; the trigger sample is at logical index pretrig.
REQ-029 Readout physical address = (trig_addr - pretrig + rd_addr) mod DEPTH, AW-bit wrap arithmetic.
REQ-030 rd_data is defined only in DONE; it is valid the cycle after rd_addr is presented.
REQ-031 When sample_en=0, no write, no counter change and no trigger evaluation occur.
REQ-032 arm and a trigger in the same cycle: arm wins, and that sample is the first sample of the new capture.
REQ-033 The buffer is a single-port-write, registered-read memory that infers block RAM.

Reset
REQ-034 With rst_n low: state=IDLE, triggered=0, done=0, trig_addr=0, rd_data=0; wr_ptr, counters and the previous-match flag clear.
REQ-035 Reset mid-capture abandons the capture; buffer contents are undefined after reset.
REQ-036 Reset deassertion takes effect on the following clk edge with no glitch on outputs.

Verification (DATA_W=8, DEPTH=16, data_i = counter incrementing each qualified cycle from 0 after arm)
REQ-037 pretrig=4, mask=FF, value=0x20, level mode -> trigger at sample 0x20; DONE after 11 post samples; rd_addr 0..15 returns 0x1C..0x2B; rd_addr 4 returns 0x20.
REQ-038 pretrig=0, mask=00 -> trigger on the first sample; DONE after 16 samples; readout 0x00..0x0F.
REQ-039 Edge mode, mask=FF, value=0x20, data held at 0x20 across arm -> no trigger; data goes to 0x21 then 0x20 -> trigger on the return to 0x20.
REQ-040 sample_en toggling 1,0,1,0 with pretrig=4, value=0x08 -> only qualified samples are stored; readout stays contiguous 0x04..0x13.
REQ-041 pretrig=4, value=0x02, then value changed to 0x30 in ARMED -> the match at 0x02 during PRE is ignored; trigger at 0x30.
REQ-042 rst_n low during POST -> state=0, done=0, triggered=0 immediately; arm in ARMED -> capture restarts with wr_ptr=0.
